// File: rtl/loop_acc.sv
// Reduction stage for the GEMM datapath: sign-extends and accumulates each
// first/last-delimited element group into one result held in a 2-entry queue.
module loop_acc #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_first,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic [CW-1:0] out_count,
  output logic          busy,
  output logic          ovf,
  output logic          err
);

  localparam int unsigned QW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [AW-1:0] data;
  } res_t;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  res_t          hd_q, hd_d;
  res_t          tl_q, tl_d;
  logic [QW-1:0] occ_q, occ_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic          accept;
  logic          start;
  logic          push;
  logic          pop;
  logic [AW-1:0] sext_data;
  logic [AW-1:0] sum;
  logic          add_ovf;
  res_t          res;

  // Element decode and the group arithmetic shared by FSM and queue.
  always_comb begin
    accept    = in_valid & in_ready_q;
    start     = in_first | (state_q == IDLE);
    sext_data = AW'($signed(in_data));
    sum       = acc_q + sext_data;
    add_ovf   = (acc_q[AW-1] == sext_data[AW-1]) && (sum[AW-1] != acc_q[AW-1]);
    res.data  = start ? sext_data : sum;
    res.cnt   = start ? CW'(1) : cnt_q + CW'(1);
    push      = accept & in_last;
    pop       = out_valid_q & out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Group FSM: next state, accumulator, counter and sticky flags.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    if (accept) begin
      acc_d = res.data;
      cnt_d = res.cnt;
      if (!start && add_ovf) begin
        ovf_d = 1'b1;
      end
      // A restart inside an open group drops the partial sum silently.
      if (in_first && (state_q == ACC)) begin
        err_d = 1'b1;
      end
      state_d = in_last ? IDLE : ACC;
    end
    busy_d = (state_d == ACC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  // Result queue: head slot drives the outputs and keeps its value once drained.
  always_comb begin
    hd_d  = hd_q;
    tl_d  = tl_q;
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + QW'(1);
      2'b01:   occ_d = occ_q - QW'(1);
      default: occ_d = occ_q;
    endcase
    if (pop && (occ_q == QW'(2))) begin
      hd_d = tl_q;
    end
    if (push) begin
      if ((occ_q == QW'(0)) || (pop && (occ_q == QW'(1)))) begin
        hd_d = res;
      end else begin
        tl_d = res;
      end
    end
    out_valid_d = (occ_d != QW'(0));
    in_ready_d  = (occ_d != QW'(2));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hd_q        <= '0;
      tl_q        <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      hd_q        <= hd_d;
      tl_q        <= tl_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = hd_q.data;
  assign out_count = hd_q.cnt;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_loop_acc.sv
// Directed bench for loop_acc with a result scoreboard; a narrow-accumulator
// instance shares the input stream to exercise signed overflow.
module tb_loop_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_first;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        busy;
  logic        ovf;
  logic        err;

  logic        n_in_ready;
  logic        n_out_valid;
  logic [15:0] n_out_data;
  logic [15:0] n_out_count;
  logic        n_busy;
  logic        n_ovf;
  logic        n_err;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   accepted;

  always #5 clk = ~clk;

  loop_acc #(.DW(16), .AW(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .busy(busy), .ovf(ovf), .err(err)
  );

  loop_acc #(.DW(16), .AW(16), .CW(16)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .out_count(n_out_count), .busy(n_busy), .ovf(n_ovf), .err(n_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input logic [31:0] d, input logic [15:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    sb.push_back(e);
  endtask

  // One clock: sample at the falling edge, score any handshake, then step.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_data", out_data, e.d);
        check("sb_count", 32'(out_count), 32'(e.c));
      end
    end
    accepted = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic f, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      tick();
    end
    if (!accepted) begin
      check("accept_timeout", 32'(accepted), 32'd1);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {30'd0, ovf, err}, 32'd0);
    check("rst_n_flags", {29'd0, n_in_ready, n_ovf, n_err}, 32'd4);
    rst = 1'b1;

    // Four-element group
    send(16'd3, 1'b1, 1'b0);
    check("grp_busy", 32'(busy), 32'd1);
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'd5, 1'b0, 1'b0);
    expect_res(32'd9, 16'd4);
    send(16'd2, 1'b0, 1'b1);
    check("grp_latency_valid", 32'(out_valid), 32'd1);
    check("grp_data", out_data, 32'd9);
    check("grp_count", 32'(out_count), 32'd4);
    check("grp_busy_after", 32'(busy), 32'd0);
    check("grp_flags", {30'd0, ovf, err}, 32'd0);
    tick();

    // Last while idle, no first
    expect_res(32'hFFFFFFFE, 16'd1);
    send(16'hFFFE, 1'b0, 1'b1);
    check("idle_last_err", 32'(err), 32'd0);
    tick();

    // Single element -7
    expect_res(32'hFFFFFFF9, 16'd1);
    send(16'hFFF9, 1'b1, 1'b1);
    check("single_data", out_data, 32'hFFFFFFF9);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("hold_data", out_data, 32'hFFFFFFF9);

    // Backpressure: queue fills, third element stalls
    out_ready = 1'b0;
    expect_res(32'd1, 16'd1);
    send(16'd1, 1'b1, 1'b1);
    check("bp_ready_1", 32'(in_ready), 32'd1);
    expect_res(32'd2, 16'd1);
    send(16'd2, 1'b1, 1'b1);
    check("bp_ready_full", 32'(in_ready), 32'd0);
    check("bp_head", out_data, 32'd1);
    in_valid = 1'b1;
    in_data  = 16'd3;
    in_first = 1'b1;
    in_last  = 1'b1;
    tick();
    check("bp_stalled", 32'(accepted), 32'd0);
    out_ready = 1'b1;
    expect_res(32'd3, 16'd1);
    send(16'd3, 1'b1, 1'b1);
    check("bp_pushpop_valid", 32'(out_valid), 32'd1);
    check("bp_pushpop_ready", 32'(in_ready), 32'd1);
    check("bp_pushpop_head", out_data, 32'd3);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Overflow on the 16-bit accumulator instance
    send(16'h7FFF, 1'b1, 1'b0);
    expect_res(32'h00008000, 16'd2);
    send(16'h0001, 1'b0, 1'b1);
    check("ovf_n_data", 32'(n_out_data), 32'h8000);
    check("ovf_n_count", 32'(n_out_count), 32'd2);
    check("ovf_n_flag", 32'(n_ovf), 32'd1);
    check("ovf_n_misc", {29'd0, n_out_valid, n_busy, n_err}, 32'd4);
    check("ovf_wide_flag", 32'(ovf), 32'd0);
    tick();
    expect_res(32'd5, 16'd1);
    send(16'd5, 1'b1, 1'b1);
    tick();
    check("ovf_sticky", 32'(n_ovf), 32'd1);

    // Protocol error: restart inside an open group
    send(16'd4, 1'b1, 1'b0);
    send(16'd4, 1'b0, 1'b0);
    check("err_before", 32'(err), 32'd0);
    expect_res(32'd10, 16'd1);
    send(16'd10, 1'b1, 1'b1);
    check("err_flag", 32'(err), 32'd1);
    check("err_data", out_data, 32'd10);
    check("err_count", 32'(out_count), 32'd1);
    tick();
    check("err_one_result", 32'(out_valid), 32'd0);

    // Asynchronous reset with a result queued and a group open
    out_ready = 1'b0;
    send(16'd8, 1'b1, 1'b1);
    send(16'd1, 1'b1, 1'b0);
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    check("arst_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_data", out_data, 32'd0);
    check("arst_flags", {30'd0, ovf, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    expect_res(32'd6, 16'd1);
    send(16'd6, 1'b1, 1'b1);
    check("post_rst_data", out_data, 32'd6);
    tick();
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/loop_acc.md
Name: loop_acc

Overview:
- Consumer-side reduction block for the GEMM datapath.
- The loop counters produce operand streams and mark the start and end of each inner-loop iteration group with first/last strobes. loop_acc accepts that stream, sign-extends and accumulates each group, and emits one dot-product result per group.
- Results are buffered in a 2-entry output queue behind a valid/ready handshake, feeding the result writer to DMA.

Parameters:
- DW, 16, width of signed input element.
- AW, 32, width of signed accumulator and result.
- CW, 16, width of per-group element counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low: all state cleared while rst==0.
- in_valid  in  1  input element present this cycle.
- in_ready  out  1  block can accept an element; high iff output queue holds fewer than 2 entries.
- in_data  in  DW  signed element.
- in_first  in  1  element is the first of a group.
- in_last  in  1  element is the last of a group.
- out_valid  out  1  output queue non-empty.
- out_ready  in  1  downstream accepts the head result.
- out_data  out  AW  head result, the accumulated sum.
- out_count  out  CW  number of elements in the head result's group.
- busy  out  1  a group is open (state ACC).
- ovf  out  1  sticky: signed overflow seen in any accumulation.
- err  out  1  sticky: protocol error (in_first received while a group is open).

Behaviour:
- Accept: an element is accepted when in_valid & in_ready. Elements with in_valid=0 or in_ready=0 have no effect.
- Reset (rst==0, asynchronous):
  - state=IDLE, acc=0, cnt=0, queue emptied.
  - in_ready=1, out_valid=0, out_data=0, out_count=0, busy=0, ovf=0, err=0.
  - Reset mid-group discards the partial sum and any queued results.
- States:
  - IDLE: no open group.
  - ACC: group open; busy=1.
- Start value: an accepted element starts a new group when in_first=1 or state==IDLE. On start, acc <= sext(in_data) and cnt <= 1.
- Continue: otherwise acc <= acc + sext(in_data) and cnt <= cnt+1.
- Arithmetic:
  - Addition wraps modulo 2^AW.
  - ovf is set when both operands have equal sign and the sum sign differs.
  - cnt wraps modulo 2^CW with no flag.
- Error case: in_first accepted while in ACC.
  - The partial sum is discarded with no output.
  - A new group starts with this element.
  - err is set.
- Last element: an accepted element with in_last=1 pushes {final acc value including this element, final cnt} into the queue. State returns to IDLE.
  - in_first & in_last on the same element gives a single-element group: result = sext(in_data), count = 1.
  - in_last while IDLE without in_first is also a single-element group, with no error.
- Transitions:
  - IDLE→ACC on an accepted element with in_last=0.
  - ACC→IDLE on an accepted element with in_last=1.
  - All other cases hold state.
- Latency: out_valid rises in the cycle after the last element is accepted, when the queue was empty. Result order is FIFO.
- Queue: 2 entries.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle: occupancy unchanged, data order preserved.
  - When full, in_ready=0, so no push can occur while full.
  - in_ready is a function of registered occupancy only; no combinational path from out_ready.
- out_data/out_count:
  - Show the head entry while out_valid=1.
  - Hold the last popped value when the queue is empty (0 after reset).
- ovf and err clear only on reset.

Test Plan:
- Reset, then group {3, -1, 5, 2} with first on element 0 and last on element 3, out_ready=1 → one result: out_data=9, out_count=4, one cycle after last accepted; busy low afterwards; ovf=0, err=0.
- Single element -7 with first & last together → out_data=0xFFFFFFF9, out_count=1.
- out_ready=0, three back-to-back single-element groups {1}, {2}, {3} → in_ready drops after the 2nd result is queued; element 3 is stalled. Then out_ready=1 → results 1, 2, 3 in order with no loss; simultaneous push/pop keeps occupancy.
- DW=16, AW=16 build: group {0x7FFF, 0x0001} → out_data=0x8000, ovf=1 and stays 1 after the next clean group.
- Group {4, 4} without last, then first with element 10 and last → err=1; one result only: out_data=10, out_count=1.
- Assert rst low mid-group and with 1 result queued → out_valid=0, busy=0 immediately (asynchronous). After release, group {6} → out_data=6.
